// File: rtl/indian_poker_bet_ctrl.sv
// Indian Poker betting controller: N players, W-bit bets with per-player
// floors, a shared ceiling, turn sequencing and round resolution.
module indian_poker_bet_ctrl #(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int TW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            Up,
    input  logic            Down,
    input  logic            set,
    input  logic [W-1:0]    Max,
    input  logic [N*W-1:0]  min,
    input  logic [N-1:0]    win,
    output logic [TW-1:0]   turn,
    output logic [N*W-1:0]  v,
    output logic [W+TW-1:0] pot,
    output logic            EN,
    output logic [N-1:0]    winner,
    output logic            err
);

    typedef enum logic [1:0] {LOAD, BET, RESOLVE, DONE} state_t;

    state_t state, state_nx;

    logic [2:0]            s, p, pulse;
    logic                  up_p, dn_p, set_p;
    logic [N-1:0][W-1:0]   bet;
    logic [N-1:0][W-1:0]   floor_v;
    logic [W+TW-1:0]       sum;
    logic                  onehot;
    logic                  last;

    assign floor_v = min;
    assign v       = bet;
    assign pulse   = s & ~p;
    assign up_p    = pulse[0];
    assign dn_p    = pulse[1];
    assign set_p   = pulse[2];
    assign last    = (turn == TW'(N - 1));

    // History flops reset high so a button held through reset never pulses
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            s <= '1;
            p <= '1;
        end else begin
            s <= {set, Down, Up};
            p <= s;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= LOAD;
            EN    <= 1'b0;
        end else begin
            state <= state_nx;
            EN    <= (state_nx == BET);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    state_nx = BET;
            BET:     if (set_p && last) state_nx = RESOLVE;
            RESOLVE: state_nx = DONE;
            DONE:    if (set_p) state_nx = LOAD;
        endcase
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + (W + TW)'(bet[i]);
        end
    end

    assign onehot = (win != '0) && ((win & (win - N'(1))) == '0);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            turn   <= '0;
            bet    <= '0;
            pot    <= '0;
            winner <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        bet[i] <= (floor_v[i] > Max) ? Max : floor_v[i];
                    end
                    turn   <= '0;
                    winner <= '0;
                    err    <= 1'b0;
                end
                BET: begin
                    if (set_p) begin
                        if (!last) turn <= turn + TW'(1);
                    end else if (up_p && !dn_p) begin
                        if (bet[turn] < Max)
                            bet[turn] <= bet[turn] + W'(1);
                    end else if (dn_p && !up_p) begin
                        if (bet[turn] > floor_v[turn])
                            bet[turn] <= bet[turn] - W'(1);
                    end
                end
                RESOLVE: begin
                    pot    <= sum;
                    winner <= onehot ? win : '0;
                    err    <= !onehot;
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_indian_poker_bet_ctrl.sv
// Directed bench for indian_poker_bet_ctrl: 2-player table-driven round
// sequence plus a 4-player overflow and mid-round reset sequence.
module tb_indian_poker_bet_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        clr1, up1, dn1, st1;
    logic [7:0]  max1;
    logic [15:0] min1;
    logic [1:0]  win1;
    logic [0:0]  turn1;
    logic [15:0] v1;
    logic [8:0]  pot1;
    logic        en1;
    logic [1:0]  winner1;
    logic        err1;

    logic        clr2, up2, dn2, st2;
    logic [3:0]  max2;
    logic [15:0] min2;
    logic [3:0]  win2;
    logic [1:0]  turn2;
    logic [15:0] v2;
    logic [5:0]  pot2;
    logic        en2;
    logic [3:0]  winner2;
    logic        err2;

    indian_poker_bet_ctrl #(.W(8), .N(2)) dut1 (
        .CLK(CLK), .CLR(clr1), .Up(up1), .Down(dn1), .set(st1),
        .Max(max1), .min(min1), .win(win1), .turn(turn1), .v(v1),
        .pot(pot1), .EN(en1), .winner(winner1), .err(err1)
    );

    indian_poker_bet_ctrl #(.W(4), .N(4)) dut2 (
        .CLK(CLK), .CLR(clr2), .Up(up2), .Down(dn2), .set(st2),
        .Max(max2), .min(min2), .win(win2), .turn(turn2), .v(v2),
        .pot(pot2), .EN(en2), .winner(winner2), .err(err2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // op mask: 1 = Up, 2 = Down, 4 = set; held 2 cycles, released 2 cycles
    task automatic press(input int d, input int op);
        if (d == 1) begin
            up1 = op[0]; dn1 = op[1]; st1 = op[2];
        end else begin
            up2 = op[0]; dn2 = op[1]; st2 = op[2];
        end
        tick(); tick();
        up1 = 0; dn1 = 0; st1 = 0;
        up2 = 0; dn2 = 0; st2 = 0;
        tick(); tick();
    endtask

    typedef struct {
        int         op;
        int         reps;
        logic [1:0] win;
        logic [7:0] v0;
        logic [7:0] v1;
        logic       t;
        logic       en;
        logic [1:0] wn;
        logic       er;
        logic [8:0] pt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1, 10, 2'b00, 8'd8, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[1]  = '{2, 10, 2'b00, 8'd2, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[2]  = '{1, 3,  2'b00, 8'd5, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[3]  = '{3, 1,  2'b00, 8'd5, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[4]  = '{4, 1,  2'b00, 8'd5, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[5]  = '{1, 3,  2'b00, 8'd5, 8'd3, 1'b1, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[6]  = '{2, 1,  2'b00, 8'd5, 8'd2, 1'b1, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[7]  = '{1, 1,  2'b00, 8'd5, 8'd3, 1'b1, 1'b1, 2'b00, 1'b0, 9'd0};
        tbl[8]  = '{4, 1,  2'b10, 8'd5, 8'd3, 1'b1, 1'b0, 2'b10, 1'b0, 9'd8};
        tbl[9]  = '{1, 1,  2'b10, 8'd5, 8'd3, 1'b1, 1'b0, 2'b10, 1'b0, 9'd8};
        tbl[10] = '{4, 1,  2'b10, 8'd2, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd8};
        tbl[11] = '{5, 1,  2'b10, 8'd2, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 9'd8};
        tbl[12] = '{4, 1,  2'b11, 8'd2, 8'd0, 1'b1, 1'b0, 2'b00, 1'b1, 9'd2};
        tbl[13] = '{4, 1,  2'b11, 8'd2, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd2};
        tbl[14] = '{2, 1,  2'b11, 8'd2, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 9'd2};

        clr1 = 0; clr2 = 0;
        up1 = 1; dn1 = 0; st1 = 0;
        up2 = 0; dn2 = 0; st2 = 0;
        max1 = 8'd8; min1 = {8'd0, 8'd2}; win1 = 2'b00;
        max2 = 4'd15; min2 = 16'h0000; win2 = 4'b0000;

        tick(); tick(); tick();
        chk("rst_v", v1, 0);
        chk("rst_pot", pot1, 0);
        chk("rst_en", en1, 0);
        chk("rst_turn", turn1, 0);
        chk("rst_winner", winner1, 0);
        chk("rst_err", err1, 0);

        clr1 = 1; clr2 = 1;
        tick();
        chk("load_v", v1, {8'd0, 8'd2});
        tick();
        chk("load_en", en1, 1);
        up1 = 0;
        tick(); tick();
        chk("held_up_no_pulse", v1, {8'd0, 8'd2});

        for (int r = 0; r < 15; r++) begin
            win1 = tbl[r].win;
            for (int k = 0; k < tbl[r].reps; k++) press(1, tbl[r].op);
            chk($sformatf("row%0d_v", r), v1, {tbl[r].v1, tbl[r].v0});
            chk($sformatf("row%0d_turn", r), turn1, tbl[r].t);
            chk($sformatf("row%0d_en", r), en1, tbl[r].en);
            chk($sformatf("row%0d_winner", r), winner1, tbl[r].wn);
            chk($sformatf("row%0d_err", r), err1, tbl[r].er);
            chk($sformatf("row%0d_pot", r), pot1, tbl[r].pt);
        end

        for (int pl = 0; pl < 4; pl++) begin
            for (int k = 0; k < 15; k++) press(2, 1);
            if (pl == 3) win2 = 4'b0100;
            press(2, 4);
        end
        chk("n4_pot", pot2, 60);
        chk("n4_v", v2, 16'hFFFF);
        chk("n4_winner", winner2, 4'b0100);
        chk("n4_err", err2, 0);
        chk("n4_en", en2, 0);

        press(2, 4);
        chk("n4_reload_v", v2, 0);
        chk("n4_reload_en", en2, 1);
        press(2, 1);
        press(2, 4);
        press(2, 4);
        chk("n4_turn2", turn2, 2);
        chk("n4_v_before_rst", v2, 16'h0001);

        @(negedge CLK);
        clr2 = 0;
        #1;
        chk("async_rst_turn", turn2, 0);
        chk("async_rst_v", v2, 0);
        chk("async_rst_en", en2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
